rotary_quad_decoder: RTL and testbench

Parametrised multi-channel quadrature (rotary) encoder decoder. It synchronises and debounces the raw A/B contacts of N_CH mechanical encoders, decodes the Gray sequence in X1, X2 or X4 resolution, and maintains a signed position counter per channel. Each channel also reports a one-cycle step strobe with direction and a sticky illegal-transition flag. It sits between the board-level encoder pins and the user-interface/control logic, and runs in the single system clock domain.

---
 rtl/rotary_quad_decoder.sv | 145 ++++++++++++++
 tb/tb_rotary_quad_decoder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_quad_decoder.sv
// Multi-channel quadrature encoder decoder: per-channel 2-FF synchroniser, debouncer,
// X1/X2/X4 Gray decoder and signed position counter with wrap or saturation.
module rotary_quad_decoder #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEB_CYC = 1000,
    parameter int unsigned MODE    = 4,
    parameter int unsigned WRAP    = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         enc_a,
    input  logic [N_CH-1:0]         enc_b,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH*CNT_W-1:0]   position,
    output logic [N_CH-1:0]         step_valid,
    output logic [N_CH-1:0]         step_dir,
    output logic [N_CH-1:0]         err
);

    localparam int unsigned        DebW    = $clog2(DEB_CYC + 1);
    localparam logic [DebW-1:0]    DebLast = DebW'(DEB_CYC - 1);
    localparam logic [DebW-1:0]    DebMax  = DebW'(DEB_CYC);
    localparam logic [DebW-1:0]    DebOne  = DebW'(1);
    localparam logic [CNT_W-1:0]   PosMax  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]   PosMin  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]   PosOne  = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync1_q, sync2_q;
        logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
        logic [1:0]       fab_q, fab_d;
        logic             load_q, load_d;
        logic [1:0]       pab_q, pab_d;
        logic             primed_q, primed_d;
        logic [CNT_W-1:0] pos_q, pos_d;
        logic             step_q, step_d;
        logic             dir_q, dir_d;
        logic             err_q, err_d;
        logic             fwd, rev, illegal, counts;

        // Counter restarts on any change of the synchronised pair; fab loads exactly once
        // when the pair has been stable for DEB_CYC cycles.
        always_comb begin
            deb_cnt_d = deb_cnt_q;
            fab_d     = fab_q;
            load_d    = 1'b0;
            if (sync1_q != sync2_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q != DebMax) begin
                deb_cnt_d = deb_cnt_q + DebOne;
            end
            if (deb_cnt_q == DebLast) begin
                fab_d  = sync2_q;
                load_d = 1'b1;
            end
        end

        always_comb begin
            fwd     = 1'b0;
            rev     = 1'b0;
            illegal = 1'b0;
            case ({pab_q, fab_q})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev     = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
                default: ;
            endcase
            if (MODE == 1) begin
                counts = (fab_q == 2'b00);
            end else if (MODE == 2) begin
                counts = (fab_q[1] == fab_q[0]);
            end else begin
                counts = 1'b1;
            end
        end

        always_comb begin
            primed_d = primed_q;
            pab_d    = pab_q;
            pos_d    = pos_q;
            step_d   = 1'b0;
            dir_d    = dir_q;
            err_d    = err_q;
            if (load_q) begin
                primed_d = 1'b1;
                pab_d    = fab_q;
                if (primed_q) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if ((fwd || rev) && counts) begin
                        step_d = 1'b1;
                        dir_d  = fwd;
                        if (fwd) begin
                            if (WRAP != 0 || pos_q != PosMax) pos_d = pos_q + PosOne;
                        end else begin
                            if (WRAP != 0 || pos_q != PosMin) pos_d = pos_q - PosOne;
                        end
                    end
                end
            end
            // Clear wins over a same-cycle step; decoder history is kept.
            if (clr[i]) begin
                pos_d  = '0;
                err_d  = 1'b0;
                step_d = 1'b0;
                dir_d  = dir_q;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync1_q   <= 2'b00;
                sync2_q   <= 2'b00;
                deb_cnt_q <= '0;
                fab_q     <= 2'b00;
                load_q    <= 1'b0;
                pab_q     <= 2'b00;
                primed_q  <= 1'b0;
                pos_q     <= '0;
                step_q    <= 1'b0;
                dir_q     <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                sync1_q   <= {enc_a[i], enc_b[i]};
                sync2_q   <= sync1_q;
                deb_cnt_q <= deb_cnt_d;
                fab_q     <= fab_d;
                load_q    <= load_d;
                pab_q     <= pab_d;
                primed_q  <= primed_d;
                pos_q     <= pos_d;
                step_q    <= step_d;
                dir_q     <= dir_d;
                err_q     <= err_d;
            end
        end

        assign position[i*CNT_W +: CNT_W] = pos_q;
        assign step_valid[i]              = step_q;
        assign step_dir[i]                = dir_q;
        assign err[i]                     = err_q;
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Bench for rotary_quad_decoder: three configurations share the same encoder stimulus;
// a sequence-level model predicts steps, positions and err flags.
module tb_rotary_quad_decoder;

    localparam int N_CH  = 2;
    localparam int CNT_W = 8;
    localparam int DEB   = 4;
    localparam int NI    = 3;

    typedef struct {
        int inst;
        int ch;
        int dir;
        int pos;
        int cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [1:0]            ab [N_CH];
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       enc_a, enc_b;
    logic [N_CH*CNT_W-1:0] pos_w [NI];
    logic [N_CH-1:0]       sv_w [NI];
    logic [N_CH-1:0]       dir_w [NI];
    logic [N_CH-1:0]       err_w [NI];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_q [$];
    exp_t mon_e;
    int   fwd_n [NI][N_CH];
    int   rev_n [NI][N_CH];

    // Model state
    logic [1:0] m_prev [N_CH];
    int         m_run [N_CH];
    bit         m_primed [N_CH];
    logic [1:0] m_pab [N_CH];
    bit         m_pend [N_CH];
    logic [1:0] m_pv [N_CH];
    int         m_due [N_CH];
    int         m_pos [NI][N_CH];
    bit         m_err [NI][N_CH];

    assign enc_a = {ab[1][1], ab[0][1]};
    assign enc_b = {ab[1][0], ab[0][0]};

    always #5 clk = ~clk;

    rotary_quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYC(DEB), .MODE(4), .WRAP(1)) u_x4 (
        .clk(clk), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .position(pos_w[0]), .step_valid(sv_w[0]), .step_dir(dir_w[0]), .err(err_w[0])
    );
    rotary_quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYC(DEB), .MODE(1), .WRAP(1)) u_x1 (
        .clk(clk), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .position(pos_w[1]), .step_valid(sv_w[1]), .step_dir(dir_w[1]), .err(err_w[1])
    );
    rotary_quad_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYC(DEB), .MODE(4), .WRAP(0)) u_sat (
        .clk(clk), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .position(pos_w[2]), .step_valid(sv_w[2]), .step_dir(dir_w[2]), .err(err_w[2])
    );

    function automatic int mode_of(input int j);
        return (j == 1) ? 1 : 4;
    endfunction

    function automatic int wrap_of(input int j);
        return (j == 2) ? 0 : 1;
    endfunction

    // Forward rotation visits the levels in this order.
    function automatic logic [1:0] seq_at(input int i);
        logic [1:0] s [4];
        s = '{2'b00, 2'b10, 2'b11, 2'b01};
        return s[i % 4];
    endfunction

    function automatic int seq_idx(input logic [1:0] v);
        for (int i = 0; i < 4; i++) if (seq_at(i) == v) return i;
        return 0;
    endfunction

    function automatic bit mode_counts(input int j, input logic [1:0] v);
        if (mode_of(j) == 1) return v == 2'b00;
        if (mode_of(j) == 2) return (v == 2'b00) || (v == 2'b11);
        return 1'b1;
    endfunction

    function automatic int bump(input int j, input int p, input int delta);
        int lim_hi, lim_lo, r;
        lim_hi = (1 << (CNT_W - 1)) - 1;
        lim_lo = -(1 << (CNT_W - 1));
        r = p + delta;
        if (wrap_of(j) != 0) begin
            if (r > lim_hi) r -= (1 << CNT_W);
            if (r < lim_lo) r += (1 << CNT_W);
        end else begin
            if (r > lim_hi) r = lim_hi;
            if (r < lim_lo) r = lim_lo;
        end
        return r;
    endfunction

    function automatic int pos_of(input int j, input int ch);
        return int'($signed(pos_w[j][ch*CNT_W +: CNT_W]));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_prev[ch]   = 2'b00;
            m_run[ch]    = 0;
            m_primed[ch] = 1'b0;
            m_pab[ch]    = 2'b00;
            m_pend[ch]   = 1'b0;
            for (int j = 0; j < NI; j++) begin
                m_pos[j][ch] = 0;
                m_err[j][ch] = 1'b0;
            end
        end
        sb_q.delete();
    endtask

    task automatic model_decode(input int ch, input logic [1:0] v);
        int d;
        if (!m_primed[ch]) begin
            m_primed[ch] = 1'b1;
        end else begin
            d = (seq_idx(v) - seq_idx(m_pab[ch]) + 4) % 4;
            for (int j = 0; j < NI; j++) begin
                if (!clr[ch]) begin
                    if (d == 2) begin
                        m_err[j][ch] = 1'b1;
                    end else if (d != 0 && mode_counts(j, v)) begin
                        m_pos[j][ch] = bump(j, m_pos[j][ch], (d == 1) ? 1 : -1);
                        sb_q.push_back('{j, ch, (d == 1) ? 1 : 0, m_pos[j][ch], cyc});
                    end
                end
            end
        end
        m_pab[ch] = v;
    endtask

    // Model: a raw level seen on DEB consecutive samples is accepted; its effect shows
    // three edges later.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rstn) begin
                model_reset();
            end else begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (m_pend[ch] && m_due[ch] == cyc) begin
                        m_pend[ch] = 1'b0;
                        model_decode(ch, m_pv[ch]);
                    end
                    if (clr[ch]) begin
                        for (int j = 0; j < NI; j++) begin
                            m_pos[j][ch] = 0;
                            m_err[j][ch] = 1'b0;
                        end
                    end
                    if (m_run[ch] == 0 || ab[ch] != m_prev[ch]) begin
                        m_run[ch]  = 1;
                        m_prev[ch] = ab[ch];
                    end else begin
                        m_run[ch]++;
                    end
                    if (m_run[ch] == DEB) begin
                        m_pend[ch] = 1'b1;
                        m_pv[ch]   = ab[ch];
                        m_due[ch]  = cyc + 3;
                    end
                end
            end
        end
    end

    // Monitor: every step pulse must match the oldest expectation for its instance/channel.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int j = 0; j < NI; j++) begin
                    for (int ch = 0; ch < N_CH; ch++) begin
                        if (sv_w[j][ch]) begin
                            k = -1;
                            for (int q = 0; q < sb_q.size(); q++) begin
                                if (sb_q[q].inst == j && sb_q[q].ch == ch) begin
                                    k = q;
                                    break;
                                end
                            end
                            if (k < 0) begin
                                chk($sformatf("unexpected_step i%0d c%0d", j, ch), 1, 0);
                            end else begin
                                mon_e = sb_q[k];
                                sb_q.delete(k);
                                chk($sformatf("step_dir i%0d c%0d", j, ch),
                                    int'(dir_w[j][ch]), mon_e.dir);
                                chk($sformatf("step_pos i%0d c%0d", j, ch), pos_of(j, ch),
                                    mon_e.pos);
                                chk($sformatf("step_cycle i%0d c%0d", j, ch), cyc, mon_e.cyc);
                                if (dir_w[j][ch]) fwd_n[j][ch]++;
                                else rev_n[j][ch]++;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic set_ab(input int ch, input logic [1:0] v, input int n);
        ab[ch] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [N_CH-1:0] m);
        clr = m;
        @(negedge clk);
        clr = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < NI; j++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                chk($sformatf("%s_pos i%0d c%0d", tag, j, ch), pos_of(j, ch), m_pos[j][ch]);
                chk($sformatf("%s_err i%0d c%0d", tag, j, ch), int'(err_w[j][ch]),
                    int'(m_err[j][ch]));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int j = 0; j < NI; j++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                chk($sformatf("%s_pos i%0d c%0d", tag, j, ch), pos_of(j, ch), 0);
                chk($sformatf("%s_sv i%0d c%0d", tag, j, ch), int'(sv_w[j][ch]), 0);
                chk($sformatf("%s_dir i%0d c%0d", tag, j, ch), int'(dir_w[j][ch]), 0);
                chk($sformatf("%s_err i%0d c%0d", tag, j, ch), int'(err_w[j][ch]), 0);
            end
        end
    endtask

    task automatic run_chan(input int ch, input int dirn, input int n);
        int i, nxt, nb;
        i = seq_idx(ab[ch]);
        for (int s = 0; s < n; s++) begin
            nxt = (i + dirn + 4) % 4;
            if ($urandom_range(0, 2) == 0) begin
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) begin
                    set_ab(ch, seq_at(nxt), int'($urandom_range(1, 3)));
                    set_ab(ch, seq_at(i), int'($urandom_range(1, 3)));
                end
            end
            set_ab(ch, seq_at(nxt), int'($urandom_range(5, 12)));
            i = nxt;
        end
    endtask

    initial begin
        int f0, r0, s0;
        for (int j = 0; j < NI; j++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                fwd_n[j][ch] = 0;
                rev_n[j][ch] = 0;
            end
        end
        clr   = '0;
        ab[0] = 2'b11;
        ab[1] = 2'b00;
        rstn  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        // Priming with ch0 at 11: no steps, no err.
        repeat (20) @(negedge clk);
        check_zero("prime");

        set_ab(0, 2'b01, 10);
        set_ab(0, 2'b00, 10);
        pulse_clr(2'b01);
        check_all("clr0");

        // X4 forward then reverse on ch0.
        f0 = fwd_n[0][0];
        for (int i = 1; i <= 4; i++) set_ab(0, seq_at(i), 10);
        chk("x4_fwd_pos", pos_of(0, 0), 4);
        chk("x4_fwd_steps", fwd_n[0][0] - f0, 4);
        chk("x1_fwd_pos", pos_of(1, 0), 1);
        r0 = rev_n[0][0];
        for (int i = 3; i >= 0; i--) set_ab(0, seq_at(i), 10);
        chk("x4_rev_pos", pos_of(0, 0), 0);
        chk("x4_rev_steps", rev_n[0][0] - r0, 4);
        chk("x1_rev_pos", pos_of(1, 0), 0);
        check_all("x4");

        // Debounce on ch1.
        s0 = fwd_n[0][1] + rev_n[0][1];
        set_ab(1, 2'b10, 3);
        set_ab(1, 2'b00, 12);
        chk("glitch_steps", fwd_n[0][1] + rev_n[0][1] - s0, 0);
        chk("glitch_pos", pos_of(0, 1), 0);
        f0 = fwd_n[0][1];
        r0 = rev_n[0][1];
        set_ab(1, 2'b10, 4);
        set_ab(1, 2'b00, 12);
        chk("hold4_fwd_steps", fwd_n[0][1] - f0, 1);
        chk("hold4_rev_steps", rev_n[0][1] - r0, 1);

        // Illegal jump, clear, and a step coinciding with clear.
        set_ab(0, 2'b11, 12);
        for (int j = 0; j < NI; j++) chk($sformatf("illegal_err i%0d", j), int'(err_w[j][0]), 1);
        chk("illegal_pos", pos_of(0, 0), 0);
        pulse_clr(2'b01);
        for (int j = 0; j < NI; j++) chk($sformatf("clr_err i%0d", j), int'(err_w[j][0]), 0);
        s0 = fwd_n[0][0] + rev_n[0][0];
        ab[0] = 2'b01;
        repeat (DEB + 2) @(negedge clk);
        clr = 2'b01;
        @(negedge clk);
        clr = '0;
        repeat (8) @(negedge clk);
        chk("clr_drop_steps", fwd_n[0][0] + rev_n[0][0] - s0, 0);
        chk("clr_drop_pos", pos_of(0, 0), 0);
        check_all("illegal");

        // Wrap and saturate.
        set_ab(0, 2'b00, 10);
        pulse_clr(2'b01);
        s0 = fwd_n[2][0];
        for (int n = 0; n < 128; n++) set_ab(0, seq_at(n + 1), 6);
        repeat (10) @(negedge clk);
        chk("wrap_pos", pos_of(0, 0), -128);
        chk("sat_pos128", pos_of(2, 0), 127);
        set_ab(0, 2'b10, 6);
        set_ab(0, 2'b11, 6);
        repeat (10) @(negedge clk);
        chk("sat_pos130", pos_of(2, 0), 127);
        chk("sat_steps", fwd_n[2][0] - s0, 130);
        chk("wrap_pos130", pos_of(0, 0), -126);
        check_all("wrap");

        // Random independent rotation with bounce.
        pulse_clr(2'b11);
        fork
            run_chan(0, 1, 40);
            run_chan(1, -1, 40);
        join
        repeat (20) @(negedge clk);
        check_all("rand");

        // Reset in the middle of activity.
        ab[0] = seq_at(seq_idx(ab[0]) + 1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_all("postreset");
        set_ab(0, seq_at(seq_idx(ab[0]) + 1), 12);
        check_all("postreset_step");

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
